// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings, FSM state type and defaults for the MEM stage
//
// Contents:
//   DEFAULT_TIMEOUT  default bus-timeout limit (REQ cycles awaiting ack)
//   WSEL_*           write-back select encodings for rf_wsel
//   mem_state_t      bus controller FSM states
//   is_mem_op()      classifies an EX/MEM instruction as a data-bus access

package mem_stage_pkg;

    localparam int DEFAULT_TIMEOUT = 16;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_RAM = 2'b01;
    localparam logic [1:0] WSEL_PC4 = 2'b10;
    localparam logic [1:0] WSEL_EXT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_t;

    // A load is recognised by its write-back source, a store by ram_we.
    function automatic logic is_mem_op(input logic ram_we, input logic [1:0] wsel);
        return ram_we | (wsel == WSEL_RAM);
    endfunction

endpackage

// File: rtl/mem_dbus_ctrl.sv
// rtl/mem_dbus_ctrl.sv - data-bus access controller: FSM, timeout, bus registers, read capture
//
// Parameters:
//   TIMEOUT     REQ cycles without ack tolerated before the access is aborted (1..255)
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   mem_op      current EX/MEM instruction is a load or store
//   op_we       store (1) / load (0)
//   op_addr     byte address, op_wdata store data
//   dbus_*      registered request side and ack/rdata response side of the data bus
//   mem_stall   combinational pipeline freeze while an access is outstanding
//   bus_err     sticky timeout flag
//   rdata       captured load data (0 after a timeout)

module mem_dbus_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_op,
    input  logic        op_we,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic        bus_err,
    output logic [31:0] rdata
);

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    mem_state_t state_q;
    mem_state_t state_d;
    logic [7:0] cnt_q;
    logic       start_req;
    logic       ack_hit;
    logic       timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack is checked before the timeout so a late ack on the abort cycle still
    // completes the access normally and leaves bus_err untouched.
    always_comb begin
        state_d     = state_q;
        mem_stall   = 1'b0;
        start_req   = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    mem_stall = 1'b1;
                    start_req = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_stall = 1'b1;
                if (dbus_ack) begin
                    ack_hit = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_wdata <= 32'd0;
            cnt_q      <= 8'd0;
            bus_err    <= 1'b0;
            rdata      <= 32'd0;
        end else begin
            if (start_req) begin
                dbus_req   <= 1'b1;
                dbus_we    <= op_we;
                dbus_addr  <= op_addr;
                dbus_wdata <= op_wdata;
                cnt_q      <= 8'd0;
            end else if (ack_hit || timeout_hit) begin
                dbus_req <= 1'b0;
            end else if (state_q == ST_REQ) begin
                cnt_q <= cnt_q + 8'd1;
            end

            // Stores leave the capture register alone; an aborted access
            // returns zero so the write-back value is deterministic.
            if (ack_hit && !dbus_we) begin
                rdata <= dbus_rdata;
            end else if (timeout_hit) begin
                rdata <= 32'd0;
            end

            if (timeout_hit) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - miniRV MEM stage: data-bus access, stall, write-back select, MEM/WB registers
//
// Optional feature macro: RUN_TRACE_EN (adds pc / inst_valid trace ports and registers)
// Parameters:
//   TIMEOUT            REQ cycles awaiting ack before abort (1..255)
// Ports:
//   cpu_clk, cpu_rst   clock; asynchronous active-high reset
//   *_MEM_in           instruction fields from the EX/MEM register
//   dbus_*             data bus (registered request, ack/rdata response)
//   mem_stall          freezes upstream pipeline registers
//   bus_err            sticky bus-timeout flag
//   *_WB_in            registered MEM/WB outputs
//   pc_MEM_in/pc_WB_in, inst_valid_MEM_in/inst_valid_WB_in   trace ports (RUN_TRACE_EN only)

module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
`ifdef RUN_TRACE_EN
    input  logic [31:0] pc_MEM_in,
    input  logic        inst_valid_MEM_in,
    output logic [31:0] pc_WB_in,
    output logic        inst_valid_WB_in,
`endif
    input  logic [31:0] ext_MEM_in,
    input  logic [31:0] pc4_MEM_in,
    input  logic [4:0]  wR_MEM_in,
    input  logic        ram_we_MEM_in,
    input  logic [1:0]  rf_wsel_MEM_in,
    input  logic        rf_we_MEM_in,
    input  logic [31:0] rD2_MEM_in,
    input  logic [31:0] ALU_C_MEM_in,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic        bus_err,
    output logic [31:0] wd_WB_in,
    output logic [4:0]  wR_WB_in,
    output logic        rf_we_WB_in
);

    logic [31:0] rdata;
    logic [31:0] wd_sel;

    mem_dbus_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) u_dbus_ctrl (
        .clk        (cpu_clk),
        .rst        (cpu_rst),
        .mem_op     (is_mem_op(ram_we_MEM_in, rf_wsel_MEM_in)),
        .op_we      (ram_we_MEM_in),
        .op_addr    (ALU_C_MEM_in),
        .op_wdata   (rD2_MEM_in),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_wdata (dbus_wdata),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata),
        .mem_stall  (mem_stall),
        .bus_err    (bus_err),
        .rdata      (rdata)
    );

    // Loads only reach this mux unstalled in DONE, when rdata holds the
    // captured bus response for this instruction.
    always_comb begin
        wd_sel = ALU_C_MEM_in;
        case (rf_wsel_MEM_in)
            WSEL_ALU: wd_sel = ALU_C_MEM_in;
            WSEL_RAM: wd_sel = rdata;
            WSEL_PC4: wd_sel = pc4_MEM_in;
            WSEL_EXT: wd_sel = ext_MEM_in;
            default:  wd_sel = ALU_C_MEM_in;
        endcase
    end

    // A stalled cycle writes a bubble: write enable off, data/dest held.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wd_WB_in    <= 32'd0;
            wR_WB_in    <= 5'd0;
            rf_we_WB_in <= 1'b0;
        end else if (mem_stall) begin
            rf_we_WB_in <= 1'b0;
        end else begin
            wd_WB_in    <= wd_sel;
            wR_WB_in    <= wR_MEM_in;
            rf_we_WB_in <= rf_we_MEM_in;
        end
    end

`ifdef RUN_TRACE_EN
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_WB_in         <= 32'd0;
            inst_valid_WB_in <= 1'b0;
        end else if (mem_stall) begin
            inst_valid_WB_in <= 1'b0;
        end else begin
            pc_WB_in         <= pc_MEM_in;
            inst_valid_WB_in <= inst_valid_MEM_in;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - randomized scoreboard bench for mem_stage_unit

module tb_mem_stage_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ext_in = 0, pc4_in = 0, rd2_in = 0, alu_in = 0;
    logic [4:0]  wr_in = 0;
    logic        ram_we_in = 0, rf_we_in = 0;
    logic [1:0]  wsel_in = 0;
    logic        dbus_req, dbus_we, dbus_ack = 0;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = 0;
    logic        mem_stall, bus_err;
    logic [31:0] wd_wb;
    logic [4:0]  wr_wb;
    logic        rf_we_wb;
`ifdef RUN_TRACE_EN
    logic [31:0] pc_in = 0, pc_wb;
    logic        iv_in = 0, iv_wb;
`endif

    mem_stage_unit #(.TIMEOUT(TO)) dut (
        .cpu_clk(clk), .cpu_rst(rst),
`ifdef RUN_TRACE_EN
        .pc_MEM_in(pc_in), .inst_valid_MEM_in(iv_in),
        .pc_WB_in(pc_wb), .inst_valid_WB_in(iv_wb),
`endif
        .ext_MEM_in(ext_in), .pc4_MEM_in(pc4_in), .wR_MEM_in(wr_in),
        .ram_we_MEM_in(ram_we_in), .rf_wsel_MEM_in(wsel_in), .rf_we_MEM_in(rf_we_in),
        .rD2_MEM_in(rd2_in), .ALU_C_MEM_in(alu_in),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .mem_stall(mem_stall), .bus_err(bus_err),
        .wd_WB_in(wd_wb), .wR_WB_in(wr_wb), .rf_we_WB_in(rf_we_wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        we;
        logic [31:0] pc;
        logic        iv;
    } exp_t;

    exp_t        expq[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          exp_err = 0;
    logic [31:0] last_wd = 0;
    logic [4:0]  last_wr = 0;
    logic [31:0] last_pc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    // Write-back value chosen by the rf_wsel rule from the four candidate sources.
    function automatic logic [31:0] wb_value(input logic [1:0] sel, input logic [31:0] alu,
                                             input logic [31:0] rd, input logic [31:0] pc4,
                                             input logic [31:0] ext);
        logic [31:0] src[4];
        src[0] = alu; src[1] = rd; src[2] = pc4; src[3] = ext;
        return src[sel];
    endfunction

    task automatic apply_nop();
        ram_we_in = 0; wsel_in = 2'b00; rf_we_in = 0; wr_in = 0;
        alu_in = 0; rd2_in = 0; pc4_in = 0; ext_in = 0;
`ifdef RUN_TRACE_EN
        pc_in = 0; iv_in = 0;
`endif
    endtask

    function automatic exp_t nop_exp();
        exp_t e;
        e.wd = 0; e.wr = 0; e.we = 0; e.pc = 0; e.iv = 0;
        return e;
    endfunction

    // Short reset pulse inside one cycle; a NOP is left on the inputs and is
    // what the next clock edge commits.
    task automatic do_reset();
        rst = 1;
        dbus_ack = 0;
        apply_nop();
        #1;
        chk("rst_dbus_req", dbus_req, 0);
        chk("rst_dbus_we", dbus_we, 0);
        chk("rst_dbus_addr", dbus_addr, 0);
        chk("rst_dbus_wdata", dbus_wdata, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_wd_wb", wd_wb, 0);
        chk("rst_wr_wb", wr_wb, 0);
        chk("rst_rf_we_wb", rf_we_wb, 0);
        chk("rst_stall_nop", mem_stall, 0);
`ifdef RUN_TRACE_EN
        chk("rst_pc_wb", pc_wb, 0);
        chk("rst_iv_wb", iv_wb, 0);
`endif
        expq.delete();
        exp_err = 0;
        expq.push_back(nop_exp());
        #1 rst = 0;
    endtask

    // Issue one instruction, act as the bus slave, and check bus behaviour and latency.
    task automatic run_op(input logic ram_we, input logic [1:0] sel, input logic rfwe,
                          input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd2,
                          input logic [31:0] pc4, input logic [31:0] ext, input logic [31:0] pc,
                          input int waits, input bit tmo, input logic [31:0] rdv, input int rst_at);
        bit          memop;
        int          lat, req_exp, cycles, k;
        logic [31:0] rd;
        exp_t        e;
        memop   = ram_we || (sel == 2'b01);
        lat     = !memop ? 1 : (tmo ? 3 + TO : 3 + waits);
        req_exp = tmo ? TO + 1 : waits + 1;
        rd      = tmo ? 32'd0 : rdv;
        @(negedge clk);
        ram_we_in = ram_we; wsel_in = sel; rf_we_in = rfwe; wr_in = wr;
        alu_in = alu; rd2_in = rd2; pc4_in = pc4; ext_in = ext;
`ifdef RUN_TRACE_EN
        pc_in = pc; iv_in = 1;
`endif
        e.wd = wb_value(sel, alu, rd, pc4, ext);
        e.wr = wr; e.we = rfwe; e.pc = pc; e.iv = 1;
        expq.push_back(e);
        if (memop && tmo) exp_err = 1;
        cycles = 0;
        k = 0;
        forever begin
            #1;
            cycles++;
            if (!mem_stall) begin
                chk("done_req_low", dbus_req, 0);
                chk("latency", cycles, lat);
                if (memop) chk("req_cycles", k, req_exp);
                chk("bus_err", bus_err, exp_err);
                dbus_ack = 1'($urandom_range(0, 1));
                break;
            end
            if (dbus_req) begin
                k++;
                chk("dbus_addr", dbus_addr, alu);
                chk("dbus_we", dbus_we, ram_we);
                chk("dbus_wdata", dbus_wdata, rd2);
                if (rst_at > 0 && k == rst_at) begin
                    do_reset();
                    return;
                end
                dbus_ack   = (!tmo && k == waits + 1);
                dbus_rdata = dbus_ack ? rdv : $urandom;
            end else begin
                dbus_ack   = 1'($urandom_range(0, 1));
                dbus_rdata = $urandom;
            end
            if (cycles > lat + 8) begin
                vectors++;
                miscompares++;
                $display("FAIL op_budget: %0d cycles without completion, required %0d", cycles, lat);
                summary();
            end
            @(negedge clk);
        end
    endtask

    // Monitor: every unstalled edge commits the head of the scoreboard,
    // every stalled edge must leave a bubble.
    initial begin
        logic was_stall;
        exp_t e;
        forever begin
            @(negedge clk);
            #4 was_stall = mem_stall;
            @(posedge clk);
            #1;
            if (rst) continue;
            if (!was_stall) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL wb_commit: got a commit, expected none pending");
                end else begin
                    e = expq.pop_front();
                    chk("wd_wb", wd_wb, e.wd);
                    chk("wr_wb", wr_wb, e.wr);
                    chk("rf_we_wb", rf_we_wb, e.we);
`ifdef RUN_TRACE_EN
                    chk("pc_wb", pc_wb, e.pc);
                    chk("iv_wb", iv_wb, e.iv);
`endif
                    last_wd = e.wd; last_wr = e.wr; last_pc = e.pc;
                end
            end else begin
                chk("bubble_we", rf_we_wb, 0);
                chk("bubble_wd", wd_wb, last_wd);
                chk("bubble_wr", wr_wb, last_wr);
`ifdef RUN_TRACE_EN
                chk("bubble_iv", iv_wb, 0);
                chk("bubble_pc", pc_wb, last_pc);
`endif
            end
        end
    end

    initial begin
        logic [1:0] sel;
        logic       rw, tmo;
        apply_nop();
        repeat (3) @(negedge clk);
        #1 do_reset();

        // ALU op, load with immediate ack, store with 3 waits, load timeout, JAL.
        run_op(0, 2'b00, 1, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h40, 0, 0, 32'h0, 0);
        run_op(0, 2'b01, 1, 5'd7, 32'h100, 32'h0, 32'h0, 32'h0, 32'h44, 0, 0, 32'hDEADBEEF, 0);
        run_op(1, 2'b00, 0, 5'd0, 32'h4, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h48, 3, 0, 32'h0, 0);
        run_op(0, 2'b01, 1, 5'd9, 32'h200, 32'h0, 32'h0, 32'h0, 32'h4C, 0, 1, 32'h0, 0);
        run_op(0, 2'b10, 1, 5'd1, 32'h77, 32'h0, 32'h8, 32'h0, 32'h50, 0, 0, 32'h0, 0);
        // Reset during REQ, then the pipeline must carry on normally.
        run_op(0, 2'b01, 1, 5'd3, 32'h300, 32'h0, 32'h0, 32'h0, 32'h54, 0, 1, 32'h0, 3);
        run_op(0, 2'b01, 1, 5'd4, 32'h304, 32'h0, 32'h0, 32'h0, 32'h58, 1, 0, 32'h13572468, 0);

        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = $urandom_range(0, 4);
            sel  = (kind == 1) ? 2'b01 : (kind == 3) ? 2'b10 : (kind == 4) ? 2'b11 : 2'b00;
            rw   = (kind == 2);
            tmo  = ($urandom_range(0, 9) == 0);
            run_op(rw, sel, rw ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom),
                   $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom_range(0, 4), tmo, $urandom, 0);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            apply_nop();
            expq.push_back(nop_exp());
        end
        @(negedge clk);
        #2 chk("scoreboard_drained", expq.size(), 0);
        summary();
    end

endmodule
